// File: rtl/rc_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rc_capture_pkg
// Brief   : Register map, ID constant, STATUS bit indices, FSM encoding.
// Revision: 1.0
// ---------------------------------------------------------------------------
package rc_capture_pkg;

  localparam logic [2:0]  c_ADDR_ID       = 3'd0;
  localparam logic [2:0]  c_ADDR_CTRL     = 3'd1;
  localparam logic [2:0]  c_ADDR_STATUS   = 3'd2;
  localparam logic [2:0]  c_ADDR_HIGH     = 3'd3;
  localparam logic [2:0]  c_ADDR_PERIOD   = 3'd4;
  localparam logic [2:0]  c_ADDR_PRESCALE = 3'd5;

  localparam logic [31:0] c_ID_VALUE = 32'hEA68_0004;

  localparam int c_ST_VALID   = 0;
  localparam int c_ST_TIMEOUT = 1;
  localparam int c_ST_OVERRUN = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/rc_pwm_capture_edge_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pwm_edge_sync
// Brief   : Multi-flop synchronizer plus one-flop rise/fall detector.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic csi_MCLK_clk,
  input  logic rsi_MRST_reset,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/rc_pwm_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rc_pwm_capture
// Brief   : Avalon-MM servo PWM high-time / period capture with level IRQ.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rc_pwm_capture
  import rc_capture_pkg::*;
#(
  parameter int PRESCALE_RST = 49,
  parameter int CNT_W        = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  input  logic        coe_pwm_in,
  output logic        ins_irq_irq
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic             w_rise, w_fall, w_tick;
  logic             w_cap_high, w_cap_period, w_set_timeout;
  logic             w_wr_ctrl, w_wr_status, w_wr_presc;
  logic [2:0]       w_status_set;
  logic [31:0]      w_rd_mux;
  logic             w_unused;
  cap_state_t       r_state, w_state_nxt;

  logic [1:0]       r_ctrl;
  logic [2:0]       r_status;
  logic [CNT_W-1:0] r_high, r_period, r_hi_cnt, r_per_cnt;
  logic [15:0]      r_prescale, r_presc_cnt;
  logic [31:0]      r_readdata;

  pwm_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .csi_MCLK_clk   (csi_MCLK_clk),
    .rsi_MRST_reset (rsi_MRST_reset),
    .pwm_in         (coe_pwm_in),
    .rise           (w_rise),
    .fall           (w_fall)
  );

  assign w_tick      = (r_presc_cnt == 16'd0);
  assign w_wr_ctrl   = avs_ctrl_write & (avs_ctrl_address == c_ADDR_CTRL);
  assign w_wr_status = avs_ctrl_write & (avs_ctrl_address == c_ADDR_STATUS) & avs_ctrl_byteenable[0];
  assign w_wr_presc  = avs_ctrl_write & (avs_ctrl_address == c_ADDR_PRESCALE);
  assign w_unused    = &{1'b0, avs_ctrl_writedata[31:16], avs_ctrl_byteenable[3:2]};

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cap_high    = 1'b0;
    w_cap_period  = 1'b0;
    w_set_timeout = 1'b0;
    if (!r_ctrl[0]) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
        ST_HIGH: begin
          if (r_per_cnt == c_CNT_MAX) begin
            w_set_timeout = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else if (w_fall) begin
            w_cap_high  = 1'b1;
            w_state_nxt = ST_LOW;
          end
        end
        ST_LOW: begin
          if (r_per_cnt == c_CNT_MAX) begin
            w_set_timeout = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else if (w_rise) begin
            w_cap_period = 1'b1;
            w_state_nxt  = ST_HIGH;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Edges re-phase the prescaler so tick boundaries line up with the pulse.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_presc_cnt <= 16'(PRESCALE_RST);
    end else if (w_rise || w_fall || w_tick || !r_ctrl[0]) begin
      r_presc_cnt <= r_prescale;
    end else begin
      r_presc_cnt <= r_presc_cnt - 16'd1;
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_hi_cnt  <= '0;
      r_per_cnt <= '0;
    end else if (w_state_nxt == ST_IDLE || w_rise) begin
      r_hi_cnt  <= '0;
      r_per_cnt <= '0;
    end else if (w_tick) begin
      if (r_state == ST_HIGH && r_hi_cnt != c_CNT_MAX) r_hi_cnt <= r_hi_cnt + 1'b1;
      if (r_per_cnt != c_CNT_MAX)                      r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  assign w_status_set[c_ST_VALID]   = w_cap_high;
  assign w_status_set[c_ST_TIMEOUT] = w_set_timeout;
  assign w_status_set[c_ST_OVERRUN] = w_cap_high & r_status[c_ST_VALID];

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_ctrl     <= '0;
      r_status   <= '0;
      r_high     <= '0;
      r_period   <= '0;
      r_prescale <= 16'(PRESCALE_RST);
    end else begin
      if (w_wr_ctrl && avs_ctrl_byteenable[0]) r_ctrl <= avs_ctrl_writedata[1:0];
      if (w_wr_presc && avs_ctrl_byteenable[0]) r_prescale[7:0]  <= avs_ctrl_writedata[7:0];
      if (w_wr_presc && avs_ctrl_byteenable[1]) r_prescale[15:8] <= avs_ctrl_writedata[15:8];
      // Hardware set takes priority over a coincident write-one-to-clear.
      r_status <= (r_status & ~(w_wr_status ? avs_ctrl_writedata[2:0] : 3'b000)) | w_status_set;
      if (w_cap_high)   r_high   <= r_hi_cnt;
      if (w_cap_period) r_period <= r_per_cnt;
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (avs_ctrl_address)
      c_ADDR_ID:       w_rd_mux = c_ID_VALUE;
      c_ADDR_CTRL:     w_rd_mux = {30'd0, r_ctrl};
      c_ADDR_STATUS:   w_rd_mux = {29'd0, r_status};
      c_ADDR_HIGH:     w_rd_mux = 32'(r_high);
      c_ADDR_PERIOD:   w_rd_mux = 32'(r_period);
      c_ADDR_PRESCALE: w_rd_mux = {16'd0, r_prescale};
      default:         w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset)     r_readdata <= 32'd0;
    else if (avs_ctrl_read) r_readdata <= w_rd_mux;
  end

  assign avs_ctrl_readdata    = r_readdata;
  assign avs_ctrl_waitrequest = 1'b0;
  assign ins_irq_irq          = r_ctrl[1] & (r_status[c_ST_VALID] | r_status[c_ST_TIMEOUT]);

endmodule
`default_nettype wire
